// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared definitions for the UART transmit framer.
//   - tx_state_e : frame FSM states; the state names the bit currently on the line
//   - START_BIT / STOP_BIT / IDLE_LEVEL : serial line levels
//   - DATA_WIDTH_DEF : default payload width
package uart_tx_pkg;

  localparam int DATA_WIDTH_DEF = 8;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

endpackage

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: payload shift register and bit counter.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   load_i         : capture data_i, clear counter
//   shift_en_i     : shift right by one, advance counter
//   data_i         : parallel payload
//   bit0_o         : current LSB of the shift register
//   bit1_o         : bit that becomes the LSB after the next shift
//   done_o         : counter has reached the last payload bit
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic                  shift_en_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  bit0_o,
  output logic                  bit1_o,
  output logic                  done_o
);

  localparam int CW = $clog2(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (load_i) begin
      shift_d = data_i;
      cnt_d   = '0;
    end else if (shift_en_i) begin
      shift_d = {1'b0, shift_q[DATA_WIDTH-1:1]};
      cnt_d   = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bit0_o = shift_q[0];
  assign bit1_o = shift_q[1];
  assign done_o = (cnt_q == CW'(DATA_WIDTH - 1));

endmodule

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmit framer, one bit per CLK (baud clock).
// Frame: start bit, DATA_WIDTH data bits LSB-first, optional parity, stop bit.
//   CLK, RST    : baud clock, synchronous active-high reset
//   P_DATA      : payload, captured on accept (DATA_VALID in IDLE)
//   DATA_VALID  : request strobe, only honoured in IDLE
//   PAR_EN      : parity slot enable, latched on accept
//   par_bit     : parity from the upstream parity calculator
//   TX_OUT      : registered serial line, idles high
//   busy        : registered, high for every non-IDLE state
module uart_tx_frame
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  par_bit,
  output logic                  TX_OUT,
  output logic                  busy
);

  tx_state_e state_q, state_d;
  logic      par_en_q, par_en_d;
  logic      tx_q, tx_d;
  logic      busy_q;
  logic      load, shift_en;
  logic      bit0, bit1, done;

  uart_tx_serializer #(.DATA_WIDTH(DATA_WIDTH)) u_ser (
    .clk_i      (CLK),
    .rst_i      (RST),
    .load_i     (load),
    .shift_en_i (shift_en),
    .data_i     (P_DATA),
    .bit0_o     (bit0),
    .bit1_o     (bit1),
    .done_o     (done)
  );

  // TX_OUT and busy are registered from the next state, so the line level
  // always matches the state register on the same edge.
  always_comb begin
    state_d  = state_q;
    par_en_d = par_en_q;
    tx_d     = IDLE_LEVEL;
    load     = 1'b0;
    shift_en = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (DATA_VALID) begin
          load     = 1'b1;
          par_en_d = PAR_EN;
          state_d  = START;
          tx_d     = START_BIT;
        end
      end
      START: begin
        state_d = DATA;
        tx_d    = bit0;
      end
      DATA: begin
        if (done) begin
          // par_bit comes from a byte frozen by busy, so it is already
          // valid on the edge that enters the parity slot.
          state_d = par_en_q ? PARITY : STOP;
          tx_d    = par_en_q ? par_bit : STOP_BIT;
        end else begin
          shift_en = 1'b1;
          tx_d     = bit1;
        end
      end
      PARITY: begin
        state_d = STOP;
        tx_d    = STOP_BIT;
      end
      STOP: begin
        state_d = IDLE;
        tx_d    = IDLE_LEVEL;
      end
      default: begin
        state_d = IDLE;
        tx_d    = IDLE_LEVEL;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      par_en_q <= 1'b0;
      tx_q     <= IDLE_LEVEL;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      par_en_q <= par_en_d;
      tx_q     <= tx_d;
      busy_q   <= (state_d != IDLE);
    end
  end

  assign TX_OUT = tx_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
module tb_uart_tx_frame;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       par_bit;
  logic       TX_OUT;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  uart_tx_frame #(.DATA_WIDTH(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_EN     (PAR_EN),
    .par_bit    (par_bit),
    .TX_OUT     (TX_OUT),
    .busy       (busy)
  );

  // Upstream parity calculator: captures while busy is low, 0 = even, 1 = odd.
  logic [7:0] pc_q;
  always @(posedge CLK) if (!busy) pc_q <= P_DATA;
  assign par_bit = PAR_TYP ? ~^pc_q : ^pc_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // seq holds the expected line, first bit in the MSB position.
  task automatic send_frame(input string nm, input logic [7:0] data, input logic pe,
                            input logic pt, input logic [10:0] seq, input int len,
                            input bit tog);
    int nb = 0;
    P_DATA = data; PAR_EN = pe; PAR_TYP = pt; DATA_VALID = 1'b1;
    for (int i = 0; i < len; i++) begin
      @(posedge CLK); #1;
      if (i == 0) DATA_VALID = 1'b0;
      chk($sformatf("%s bit%0d", nm, i), 32'(TX_OUT), 32'(seq[len-1-i]));
      if (busy) nb++;
      if (tog && i == 3) begin
        P_DATA = ~data; PAR_EN = ~pe; DATA_VALID = 1'b0;
      end
    end
    @(posedge CLK); #1;
    chk({nm, " idle tx"}, 32'(TX_OUT), 32'd1);
    chk({nm, " idle busy"}, 32'(busy), 32'd0);
    chk({nm, " busy len"}, 32'(nb), 32'(len));
  endtask

  logic [7:0] drv  [0:40];
  logic       ltx  [0:40];
  logic       lbsy [0:40];

  initial begin
    RST = 1'b1; P_DATA = '0; DATA_VALID = 1'b0; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset tx", 32'(TX_OUT), 32'd1);
    chk("reset busy", 32'(busy), 32'd0);
    RST = 1'b0;
    @(posedge CLK); #1;
    chk("idle tx", 32'(TX_OUT), 32'd1);

    send_frame("a5p", 8'hA5, 1'b1, 1'b0, 11'b01010010101, 11, 1'b0);
    send_frame("07odd", 8'h07, 1'b1, 1'b1, 11'b01110000001, 11, 1'b0);
    send_frame("01np", 8'h01, 1'b0, 1'b0, 11'b00100000001, 10, 1'b0);
    // Mid-frame P_DATA/PAR_EN change must not disturb the frame.
    send_frame("a5tog", 8'hA5, 1'b1, 1'b0, 11'b01010010101, 11, 1'b1);
    // Now the toggled-to style (no parity) applies from the next accept.
    send_frame("01after", 8'h01, 1'b0, 1'b0, 11'b00100000001, 10, 1'b0);

    // Continuous DATA_VALID with P_DATA changing every cycle.
    PAR_EN = 1'b1; PAR_TYP = 1'b0; DATA_VALID = 1'b1;
    for (int c = 0; c <= 40; c++) begin
      P_DATA = 8'(8'h3C + c * 37);
      drv[c] = P_DATA;
      @(posedge CLK); #1;
      ltx[c]  = TX_OUT;
      lbsy[c] = busy;
    end
    DATA_VALID = 1'b0;
    for (int f = 0; f < 3; f++) begin
      int a = f * 12;
      logic [7:0] got = '0;
      chk($sformatf("b2b start%0d busy", f), 32'(lbsy[a]), 32'd1);
      chk($sformatf("b2b start%0d tx", f), 32'(ltx[a]), 32'd0);
      for (int b = 0; b < 8; b++) got[b] = ltx[a + 1 + b];
      chk($sformatf("b2b data%0d", f), 32'(got), 32'(drv[a]));
      chk($sformatf("b2b par%0d", f), 32'(ltx[a + 9]), 32'(^drv[a]));
      chk($sformatf("b2b gap%0d", f), 32'(lbsy[a + 11]), 32'd0);
      chk($sformatf("b2b busy10_%0d", f), 32'(lbsy[a + 10]), 32'd1);
    end
    chk("b2b start3", 32'(lbsy[36]), 32'd1);
    // let the last frame drain
    repeat (14) @(posedge CLK);
    #1;
    chk("b2b drained", 32'(busy), 32'd0);

    // Reset while data bit 3 is on the line.
    P_DATA = 8'h5A; PAR_EN = 1'b1; DATA_VALID = 1'b1;
    @(posedge CLK); #1;
    DATA_VALID = 1'b0;
    chk("rst accept busy", 32'(busy), 32'd1);
    repeat (4) @(posedge CLK);
    #1;
    chk("rst bit3 tx", 32'(TX_OUT), 32'(1'b1)); // 0x5A bit3 = 1
    chk("rst bit3 busy", 32'(busy), 32'd1);
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    chk("rst hit tx", 32'(TX_OUT), 32'd1);
    chk("rst hit busy", 32'(busy), 32'd0);
    @(posedge CLK); #1;
    chk("rst idle busy", 32'(busy), 32'd0);
    send_frame("post_rst", 8'hA5, 1'b1, 1'b0, 11'b01010010101, 11, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
